edge_gen: RTL and testbench

- Transmit-side counterpart of the edge detectors: generates a programmable train of clean, registered pulses on a single output line.
- A downstream edge detector or peripheral pin consumes the train.
- Software or an FSM supplies high width, low width, pulse count and polarity, then fires start_i.
- The block reports busy/done and emits re_o/fe_o strobes aligned with every edge it drives.

---
 rtl/edge_gen_pkg.sv | 23 ++
 rtl/edge_gen_cnt.sv | 37 +++
 rtl/edge_gen.sv | 176 +++++++++++++++++
 tb/tb_edge_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/edge_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : edge_gen_pkg
// Brief   : State encoding and width helpers shared by the edge_gen block.
// Revision: 1.0 - initial release
// ============================================================================
package edge_gen_pkg;

    // Widest counter the clamp helper supports; edge_gen casts into/out of it.
    localparam int MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    function automatic logic [MAX_W-1:0] clamp_to_one(input logic [MAX_W-1:0] v);
        return (v == '0) ? MAX_W'(1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_gen_cnt.sv
`default_nettype none
// ============================================================================
// Module  : edge_gen_cnt
// Brief   : Loadable down-counter with zero flag; saturates at zero.
// Revision: 1.0 - initial release
// ============================================================================
module edge_gen_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [CNT_WIDTH-1:0] i_load_val,
    input  logic                 i_dec,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_zero
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_one;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/edge_gen.sv
`default_nettype none
// ============================================================================
// Module  : edge_gen
// Brief   : Programmable pulse-train generator with edge strobes and done flag.
// Revision: 1.0 - initial release
// ============================================================================
module edge_gen
    import edge_gen_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CNT_WIDTH-1:0] high_i,
    input  logic [CNT_WIDTH-1:0] low_i,
    input  logic [CNT_WIDTH-1:0] num_i,
    input  logic                 pol_i,
    output logic                 dat_o,
    output logic                 re_o,
    output logic                 fe_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    state_t               r_state;
    state_t               w_next;
    logic                 r_pol;
    logic                 r_cont;
    logic [CNT_WIDTH-1:0] r_high;
    logic [CNT_WIDTH-1:0] r_low;
    logic                 r_dat;
    logic                 r_re;
    logic                 r_fe;
    logic                 r_done;

    logic                 w_accept;
    logic [CNT_WIDTH-1:0] w_high_c;
    logic [CNT_WIDTH-1:0] w_low_c;
    logic                 w_pol_next;
    logic                 w_dat_next;

    logic                 w_wload;
    logic [CNT_WIDTH-1:0] w_wval;
    logic                 w_wdec;
    logic [CNT_WIDTH-1:0] w_wcount;
    logic                 w_wzero;

    logic                 w_pload;
    logic [CNT_WIDTH-1:0] w_pval;
    logic                 w_pdec;
    logic [CNT_WIDTH-1:0] w_pcount;
    logic                 w_pzero;

    assign w_high_c = CNT_WIDTH'(clamp_to_one(MAX_W'(high_i)));
    assign w_low_c  = CNT_WIDTH'(clamp_to_one(MAX_W'(low_i)));
    assign w_accept = (r_state == ST_IDLE) && start_i && !abort_i;

    always_comb begin
        w_next  = r_state;
        w_wload = 1'b0;
        w_wval  = '0;
        w_wdec  = 1'b0;
        w_pload = 1'b0;
        w_pval  = '0;
        w_pdec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next  = ST_HIGH;
                    w_wload = 1'b1;
                    w_wval  = w_high_c - c_one;
                    w_pload = 1'b1;
                    w_pval  = num_i;
                end
            end
            ST_HIGH: begin
                if (abort_i) begin
                    w_next = ST_IDLE;
                end else if (w_wzero) begin
                    w_next  = ST_LOW;
                    w_wload = 1'b1;
                    w_wval  = r_low - c_one;
                end else begin
                    w_wdec = 1'b1;
                end
            end
            ST_LOW: begin
                if (abort_i) begin
                    w_next = ST_IDLE;
                end else if (w_wzero) begin
                    // Continuous trains keep the pulse counter at 0 forever.
                    if (r_cont || (w_pcount > c_one)) begin
                        w_next  = ST_HIGH;
                        w_wload = 1'b1;
                        w_wval  = r_high - c_one;
                        w_pdec  = (w_pcount > c_one);
                    end else begin
                        w_next = ST_IDLE;
                    end
                end else begin
                    w_wdec = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_pol_next = w_accept ? pol_i : r_pol;
    assign w_dat_next = (w_next == ST_HIGH) ? ~w_pol_next : w_pol_next;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_pol   <= 1'b0;
            r_cont  <= 1'b0;
            r_high  <= '0;
            r_low   <= '0;
            r_dat   <= 1'b0;
            r_re    <= 1'b0;
            r_fe    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pol   <= w_pol_next;
            if (w_accept) begin
                r_high <= w_high_c;
                r_low  <= w_low_c;
                r_cont <= (num_i == '0);
            end
            r_dat  <= w_dat_next;
            r_re   <= w_dat_next & ~r_dat;
            r_fe   <= ~w_dat_next & r_dat;
            r_done <= (r_state == ST_LOW) && (w_next == ST_IDLE) && !abort_i;
        end
    end

    edge_gen_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_width_cnt (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_load     (w_wload),
        .i_load_val (w_wval),
        .i_dec      (w_wdec),
        .o_count    (w_wcount),
        .o_zero     (w_wzero)
    );

    edge_gen_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pulse_cnt (
        .clk        (clk_i),
        .rst        (rst_i),
        .i_load     (w_pload),
        .i_load_val (w_pval),
        .i_dec      (w_pdec),
        .o_count    (w_pcount),
        .o_zero     (w_pzero)
    );

    // Width count value and pulse zero flag are not needed by the FSM.
    logic w_unused;
    assign w_unused = ^{w_wcount, w_pzero};

    assign dat_o  = r_dat;
    assign re_o   = r_re;
    assign fe_o   = r_fe;
    assign busy_o = (r_state != ST_IDLE);
    assign done_o = r_done;

endmodule
`default_nettype wire

// File: tb/tb_edge_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_edge_gen
// Brief   : Directed self-checking bench for edge_gen.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_edge_gen;

    localparam int CNT_WIDTH = 16;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 start_i = 1'b0;
    logic                 abort_i = 1'b0;
    logic [CNT_WIDTH-1:0] high_i = '0;
    logic [CNT_WIDTH-1:0] low_i = '0;
    logic [CNT_WIDTH-1:0] num_i = '0;
    logic                 pol_i = 1'b0;
    logic                 dat_o, re_o, fe_o, busy_o, done_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    edge_gen #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .start_i (start_i),
        .abort_i (abort_i),
        .high_i  (high_i),
        .low_i   (low_i),
        .num_i   (num_i),
        .pol_i   (pol_i),
        .dat_o   (dat_o),
        .re_o    (re_o),
        .fe_o    (fe_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    // Observed vector order: {dat, re, fe, busy, done}
    function automatic logic [4:0] obs();
        return {dat_o, re_o, fe_o, busy_o, done_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire(input int h, input int l, input int n, input logic p);
        high_i  = CNT_WIDTH'(h);
        low_i   = CNT_WIDTH'(l);
        num_i   = CNT_WIDTH'(n);
        pol_i   = p;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        tests++;
        if (obs() !== 5'b00000) begin
            fails++;
            $display("FAIL reset_state: got %b want %b", obs(), 5'b00000);
        end
        rst_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            tests++;
            if (obs() !== 5'b00000) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: got %b want %b", k, obs(), 5'b00000);
            end
        end
    endtask

    task automatic test_train();
        logic [4:0] e [12] = '{5'b11010, 5'b10010, 5'b10010, 5'b00110, 5'b00010,
                               5'b11010, 5'b10010, 5'b10010, 5'b00110, 5'b00010,
                               5'b00001, 5'b00000};
        fire(3, 2, 2, 1'b0);
        for (int k = 0; k < 12; k++) begin
            tests++;
            if (obs() !== e[k]) begin
                fails++;
                $display("FAIL train t+%0d: got %b want %b", k + 1, obs(), e[k]);
            end
            tick();
        end
    endtask

    task automatic test_clamp();
        logic [4:0] e [4] = '{5'b11010, 5'b00110, 5'b00001, 5'b00000};
        fire(0, 0, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs() !== e[k]) begin
                fails++;
                $display("FAIL clamp t+%0d: got %b want %b", k + 1, obs(), e[k]);
            end
            tick();
        end
    endtask

    task automatic test_continuous_abort();
        logic [4:0] e [8] = '{5'b11010, 5'b00110, 5'b11010, 5'b00110, 5'b11010,
                              5'b00100, 5'b00000, 5'b00000};
        fire(1, 1, 0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (obs() !== e[k]) begin
                fails++;
                $display("FAIL cont_abort t+%0d: got %b want %b", k + 1, obs(), e[k]);
            end
            abort_i = (k == 4);
            tick();
        end
        abort_i = 1'b0;
    endtask

    task automatic test_pol_high();
        // Line is already low, so entering the low-active phase gives no strobe.
        logic [4:0] e [6] = '{5'b00010, 5'b00010, 5'b11010, 5'b10010, 5'b10001, 5'b10000};
        fire(2, 2, 1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (obs() !== e[k]) begin
                fails++;
                $display("FAIL pol_high t+%0d: got %b want %b", k + 1, obs(), e[k]);
            end
            tick();
        end
    endtask

    task automatic test_busy_ignore();
        // Starts from idle level 1; the pol=0 train's active level equals it.
        logic [4:0] e [4] = '{5'b10010, 5'b00110, 5'b00001, 5'b00000};
        fire(1, 1, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs() !== e[k]) begin
                fails++;
                $display("FAIL busy_ignore t+%0d: got %b want %b", k + 1, obs(), e[k]);
            end
            if (k == 0) begin
                high_i = 16'd4; num_i = 16'd5; pol_i = 1'b1; start_i = 1'b1;
            end else begin
                start_i = 1'b0; pol_i = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e [8] = '{5'b11010, 5'b00110, 5'b00001, 5'b11010, 5'b10010,
                              5'b00110, 5'b00001, 5'b00000};
        fire(1, 1, 1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (obs() !== e[k]) begin
                fails++;
                $display("FAIL back_to_back t+%0d: got %b want %b", k + 1, obs(), e[k]);
            end
            if (k == 2) begin
                high_i = 16'd2; low_i = 16'd1; num_i = 16'd1; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_start_abort_idle();
        abort_i = 1'b1;
        fire(2, 2, 1, 1'b0);
        abort_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs() !== 5'b00000) begin
                fails++;
                $display("FAIL start_abort t+%0d: got %b want %b", k + 1, obs(), 5'b00000);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] e [4] = '{5'b11010, 5'b10010, 5'b00000, 5'b00000};
        fire(5, 1, 1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (obs() !== e[k]) begin
                fails++;
                $display("FAIL reset_mid t+%0d: got %b want %b", k + 1, obs(), e[k]);
            end
            rst_i = (k == 1);
            tick();
        end
        rst_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_train();
        test_clamp();
        test_continuous_abort();
        test_pol_high();
        test_busy_ignore();
        test_back_to_back();
        test_start_abort_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
